// File: rtl/spi_link_scheduler.sv
`timescale 1ns/1ps
// spi_link_scheduler: arbitrates NREQ requesters onto one SPI mode-0 master link.
// Optional build macro ARB_FIXED_PRIORITY_EN: lowest-index requester always wins.
module spi_link_scheduler #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic                     clockIn,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   txData,
    input  logic [DIV_W-1:0]         divSel,
    input  logic                     miso,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          done,
    output logic [DATA_W-1:0]        rxData,
    output logic                     rxValid,
    output logic                     busy,
    output logic                     sclk,
    output logic                     mosi,
    output logic [NREQ-1:0]          csN
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    typedef enum logic [2:0] {IDLE, ARB, SETUP, SHIFT, HOLD} state_t;

    state_t            state;
    state_t            nxt;
    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  cnt;
    logic [EW-1:0]     edgeCnt;
    logic [IW-1:0]     winner;
    logic [NREQ-1:0]   reqL;
    logic [NREQ-1:0]   grantR;
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] rx;
    logic              halfEnd;
    logic              lastEdge;
    logic              frame;

    assign halfEnd  = (cnt == div);
    assign lastEdge = (edgeCnt == LAST_EDGE);
    assign frame    = (state == SETUP) || (state == SHIFT) || (state == HOLD);

`ifdef ARB_FIXED_PRIORITY_EN
    // Winner is the lowest-index requester in the snapshot taken on leaving IDLE.
    always_comb begin
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (reqL[IW'(i)]) winner = IW'(i);
        end
    end
`else
    logic [IW-1:0] rrPtr;
    logic [IW-1:0] idx;
    logic          found;

    // Winner is the first snapshot requester after the previous winner, wrapping.
    always_comb begin
        winner = rrPtr;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(rrPtr) + k) % NREQ);
            if (!found && reqL[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Round-robin pointer remembers the last granted requester.
    always_ff @(posedge clockIn or posedge reset) begin
        if (reset) rrPtr <= IW'(NREQ - 1);
        else if (state == ARB) rrPtr <= winner;
    end
`endif

    // State register.
    always_ff @(posedge clockIn or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end

    // Next-state logic: one frame per grant, half-period paced by the divider.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (|req) nxt = ARB;
            ARB:     nxt = SETUP;
            SETUP:   if (halfEnd) nxt = SHIFT;
            SHIFT:   if (halfEnd && sclk && lastEdge) nxt = HOLD;
            HOLD:    if (halfEnd) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Frame datapath: divider, shift registers, sclk and completion pulses.
    always_ff @(posedge clockIn or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            div     <= '0;
            edgeCnt <= '0;
            reqL    <= '0;
            grantR  <= '0;
            tx      <= '0;
            rx      <= '0;
            sclk    <= 1'b0;
            done    <= '0;
            rxValid <= 1'b0;
            rxData  <= '0;
        end else begin
            done    <= '0;
            rxValid <= 1'b0;
            cnt     <= (frame && !halfEnd) ? cnt + 1'b1 : '0;
            unique case (state)
                IDLE: begin
                    if (|req) reqL <= req;
                end
                ARB: begin
                    grantR  <= NREQ'(1) << winner;
                    tx      <= txData[winner*DATA_W +: DATA_W];
                    div     <= divSel;
                    edgeCnt <= '0;
                    sclk    <= 1'b0;
                end
                SHIFT: begin
                    if (halfEnd) begin
                        sclk    <= ~sclk;
                        edgeCnt <= edgeCnt + 1'b1;
                        if (!sclk) rx <= {rx[DATA_W-2:0], miso};
                        else tx <= {tx[DATA_W-2:0], 1'b0};
                    end
                end
                HOLD: begin
                    if (halfEnd) begin
                        grantR  <= '0;
                        done    <= grantR;
                        rxValid <= 1'b1;
                        rxData  <= rx;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state: chip-select and mosi only inside a frame.
    always_comb begin
        busy  = (state != IDLE);
        grant = grantR;
        csN   = '1;
        mosi  = 1'b0;
        if (frame) begin
            csN  = ~grantR;
            mosi = tx[DATA_W-1];
        end
    end

endmodule

// File: doc/spi_link_scheduler.md
Name: spi_link_scheduler

Overview:
- Shares one SPI master link between NREQ router output ports.
- Round-robin arbiter grants one requester at a time. An internal programmable clock divider generates SCLK, and the block sequences one DATA_W-bit full-duplex frame per grant (SPI mode 0, MSB first).
- Sits between the router output queues and the off-chip SPI slaves; each requester owns one chip-select.

Parameters:
- NREQ, 4, number of requesters / chip-selects (2..8).
- DATA_W, 8, frame width in bits.
- DIV_W, 8, width of runtime divider select.

Ports:
- clockIn  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester transfer request, level.
- txData  input  NREQ*DATA_W  packed transmit words; slice i belongs to req[i].
- divSel  input  DIV_W  SCLK half-period = divSel+1 clockIn cycles.
- miso  input  1  serial data from slaves.
- grant  output  NREQ  one-hot; high for the whole frame of the granted requester.
- done  output  NREQ  one-cycle pulse to the granted requester at frame end.
- rxData  output  DATA_W  received word; held until the next frame end.
- rxValid  output  1  one-cycle pulse, coincident with done.
- busy  output  1  high in every state except IDLE.
- sclk  output  1  SPI clock, idle low.
- mosi  output  1  serial data to slaves.
- csN  output  NREQ  active-low chip-selects; at most one low.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clockIn.
- Reset values: grant=0, done=0, rxData=0, rxValid=0, busy=0, sclk=0, mosi=0, csN=all 1, state=IDLE, rrPtr=NREQ-1, divider counter=0.
- States and transitions:
  - IDLE: if req≠0, go to ARB next cycle.
  - ARB: 1 cycle.
    - Winner = first set req[i] scanning from rrPtr+1 upward, wrapping modulo NREQ.
    - Register grant[winner]=1 and rrPtr=winner.
    - Load shift register from txData slice; latch divSel into an internal divisor.
    - Go to SETUP.
  - SETUP: csN[winner]=0, sclk=0, mosi=shift MSB. Lasts one half-period (divisor+1 cycles).
  - SHIFT: sclk toggles at the end of every half-period, 2*DATA_W half-periods in total.
    - Rising edge: sample miso into rx LSB.
    - Falling edge: shift tx left; mosi=new MSB.
    - After the DATA_W-th falling edge (sclk low), go to HOLD.
  - HOLD: csN held low, sclk low, for one half-period. On exit:
    - csN all high, grant=0.
    - done[winner]=1 and rxValid=1 for one cycle; rxData updated.
    - Go to IDLE.
- Timing:
  - csN low duration = (2*DATA_W+2)*(divisor+1) clockIn cycles.
  - req-to-csN latency from IDLE = 2 cycles.
  - Back-to-back frames: at least one IDLE cycle with csN high between frames.
- divSel changes mid-frame are ignored; the value latched in ARB applies.
- req deasserted mid-frame: the frame completes normally. txData is sampled only in ARB.
- A requester holding req after done re-enters rotation behind all others.
- Divider counter restarts at 0 at each state entry and every half-period.
- divSel=0: sclk toggles every cycle (clockIn/2).
- divSel=2^DIV_W-1: half-period = 2^DIV_W cycles, no overflow.
- Reset asserted mid-frame: all outputs return to reset values immediately (async); no done pulse; rrPtr resets.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
- Defined: fixed-priority arbitration; lowest-index set req always wins; rrPtr not used.
- Undefined: round-robin as described.
- Frame sequencing is identical in both builds.

Test Plan:
- Reset, then req=4'b0100, txData slice2=8'hA5, divSel=0, miso tied to mosi:
  - csN[2] low 2 cycles after req; 18 cycles low; mosi bits 1,0,1,0,0,1,0,1.
  - done[2] and rxValid pulse once; rxData=8'hA5.
- req=4'b1111 held, divSel=1:
  - grants in order 0,1,2,3,0; each csN low 36 cycles.
  - never two csN low; at least 1 IDLE cycle between frames.
- divSel=3 latched, then changed to 0 during SHIFT:
  - every sclk half-period stays 4 cycles until frame end.
- req[1] pulsed high 1 cycle then dropped:
  - full frame still runs on csN[1]; done[1] pulses.
- Assert reset during the 5th sclk high phase:
  - same cycle: csN=4'hF, sclk=0, grant=0, busy=0; no done/rxValid pulse; next req restarts from requester 0.
- ARB_FIXED_PRIORITY_EN defined, req=4'b1010 held:
  - requester 1 granted on every frame; requester 3 never granted.
